// File: rtl/ram_arbiter.sv
// Arbitrates fetch and LSU access to the data RAM and turns sub-word stores into a read-modify-write.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module ram_arbiter #(
  parameter int ADDR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W+1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W+1:0] ls_addr_i,
  input  logic [3:0]        ls_be_i,
  input  logic [31:0]       ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [31:0]       ls_rdata_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [31:0]       ram_rd_data_i,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [31:0]       ram_wr_data_o
);

  typedef enum logic {IDLE, RMW} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] if_word, ls_word;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [31:0]       wr_data_q, merged, lane_mask;
  logic              if_gnt, ls_gnt;
  logic              ls_full, ls_partial, ls_rd_gnt, ls_full_gnt, ls_part_gnt;
  logic              if_rvalid_q, ls_rvalid_q;
  logic [31:0]       if_rdata_q, ls_rdata_q;
  logic              unused_addr_lsb;

  assign if_word         = if_addr_i[ADDR_W+1:2];
  assign ls_word         = ls_addr_i[ADDR_W+1:2];
  assign unused_addr_lsb = ^{if_addr_i[1:0], ls_addr_i[1:0]};

`ifdef RAM_ARB_RR_EN
  logic last_ls_q;
`endif

  // Grants are purely combinational so the requester sees acceptance in the same cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst_i && state_q == IDLE) begin
`ifdef RAM_ARB_RR_EN
      if (if_req_i && ls_req_i) begin
        if_gnt = last_ls_q;
        ls_gnt = !last_ls_q;
      end else begin
        if_gnt = if_req_i;
        ls_gnt = ls_req_i;
      end
`else
      ls_gnt = ls_req_i;
      if_gnt = if_req_i && !ls_req_i;
`endif
    end
  end

  assign ls_full     = ls_we_i && (ls_be_i == 4'hF);
  assign ls_partial  = ls_we_i && (ls_be_i != 4'h0) && (ls_be_i != 4'hF);
  assign ls_rd_gnt   = ls_gnt && (!ls_we_i || ls_partial);
  assign ls_full_gnt = ls_gnt && ls_full;
  assign ls_part_gnt = ls_gnt && ls_partial;

  assign lane_mask = {{8{ls_be_i[3]}}, {8{ls_be_i[2]}}, {8{ls_be_i[1]}}, {8{ls_be_i[0]}}};
  assign merged    = (ls_wdata_i & lane_mask) | (ram_rd_data_i & ~lane_mask);

  // Address/data outputs fall back to the last driven value when the port is idle.
  assign ram_rd_en_o   = if_gnt || ls_rd_gnt;
  assign ram_rd_addr_o = if_gnt ? if_word : (ls_rd_gnt ? ls_word : rd_addr_q);
  assign ram_wr_en_o   = ls_full_gnt || (state_q == RMW && !rst_i);
  assign ram_wr_addr_o = ls_full_gnt ? ls_word : wr_addr_q;
  assign ram_wr_data_o = ls_full_gnt ? ls_wdata_i : wr_data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ls_part_gnt) state_d = RMW;
      RMW:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      if_rvalid_q <= if_gnt;
      ls_rvalid_q <= ls_gnt && !ls_we_i;
      rd_addr_q   <= ram_rd_addr_o;
      if (if_gnt) if_rdata_q <= ram_rd_data_i;
      if (ls_gnt && !ls_we_i) ls_rdata_q <= ram_rd_data_i;
      if (ls_part_gnt) begin
        wr_addr_q <= ls_word;
        wr_data_q <= merged;
      end else if (ls_full_gnt) begin
        wr_addr_q <= ls_word;
        wr_data_q <= ls_wdata_i;
      end
    end
  end

`ifdef RAM_ARB_RR_EN
  // last_ls_q starts at 1 so fetch wins the first contention after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_ls_q <= 1'b1;
    else if (if_gnt || ls_gnt) last_ls_q <= ls_gnt;
  end
`endif

  assign if_gnt_o    = if_gnt;
  assign ls_gnt_o    = ls_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus constrained-random traffic
// checked against a transaction-level model of the shared RAM.
module tb_ram_arbiter;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [AW+1:0] if_addr = '0, ls_addr = '0;
  logic [3:0]    ls_be = '0;
  logic [31:0]   ls_wdata = '0;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [31:0]   if_rdata, ls_rdata;
  logic          ram_rd_en, ram_wr_en;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [31:0]   ram_rd_data, ram_wr_data;

  // RAM behaviour: combinational read, write at the edge, plus a preload port for the bench.
  logic [31:0]   mem [256] = '{default: 32'h0};
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;
  assign ram_rd_data = mem[ram_rd_addr];
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_be_i(ls_be),
    .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data),
    .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model: expected memory contents, a pending merged write, and arbitration history.
  logic [31:0]   ref_mem [256] = '{default: 32'h0};
  logic          m_busy = 1'b0;
  logic [AW-1:0] m_pend_addr = '0;
  logic [31:0]   m_pend_data = '0;
  logic          m_last_ls = 1'b1;
  logic          m_if_rv = 1'b0, m_ls_rv = 1'b0;
  logic [31:0]   m_if_rdata = '0, m_ls_rdata = '0;
  logic          g_if, g_ls, g_rd, g_wr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = nw[8*n +: 8];
    return w;
  endfunction

  // One clock: drive, check the combinational response, advance the model, check registered outputs.
  task automatic cycle(input logic r, input logic ireq, input logic [AW+1:0] iaddr,
                       input logic lreq, input logic we, input logic [AW+1:0] laddr,
                       input logic [3:0] be, input logic [31:0] wd);
    logic e_if, e_ls, e_ls_rd, e_full, e_part, e_wr;
    logic [AW-1:0] iw, lw;
    @(negedge clk);
    rst = r; if_req = ireq; if_addr = iaddr;
    ls_req = lreq; ls_we = we; ls_addr = laddr; ls_be = be; ls_wdata = wd;
    #1;
    iw = iaddr[AW+1:2];
    lw = laddr[AW+1:2];
    e_if = 1'b0;
    e_ls = 1'b0;
    if (!r && !m_busy) begin
      if (ireq && lreq) begin
`ifdef RAM_ARB_RR_EN
        e_if = m_last_ls;
        e_ls = !m_last_ls;
`else
        e_ls = 1'b1;
`endif
      end else begin
        e_if = ireq;
        e_ls = lreq;
      end
    end
    e_full  = e_ls && we && be == 4'hF;
    e_part  = e_ls && we && be != 4'h0 && be != 4'hF;
    e_ls_rd = e_ls && (!we || e_part);
    e_wr    = e_full || (m_busy && !r);
    g_if = if_gnt; g_ls = ls_gnt; g_rd = ram_rd_en; g_wr = ram_wr_en;
    check("if_gnt", if_gnt, e_if);
    check("ls_gnt", ls_gnt, e_ls);
    check("rd_en", ram_rd_en, e_if || e_ls_rd);
    check("wr_en", ram_wr_en, e_wr);
    if (e_if) check("rd_addr_if", ram_rd_addr, iw);
    if (e_ls_rd) check("rd_addr_ls", ram_rd_addr, lw);
    if (e_full) begin
      check("wr_addr_full", ram_wr_addr, lw);
      check("wr_data_full", ram_wr_data, wd);
    end
    if (m_busy && !r) begin
      check("wr_addr_rmw", ram_wr_addr, m_pend_addr);
      check("wr_data_rmw", ram_wr_data, m_pend_data);
    end
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0; m_last_ls = 1'b1;
      m_if_rv = 1'b0; m_ls_rv = 1'b0; m_if_rdata = '0; m_ls_rdata = '0;
    end else begin
      m_if_rv = e_if;
      m_ls_rv = e_ls && !we;
      if (e_if) m_if_rdata = ref_mem[iw];
      if (e_ls && !we) m_ls_rdata = ref_mem[lw];
      if (m_busy) ref_mem[m_pend_addr] = m_pend_data;
      if (e_full) ref_mem[lw] = wd;
      if (e_part) begin
        m_pend_addr = lw;
        m_pend_data = merge(ref_mem[lw], wd, be);
      end
      m_busy = e_part;
      if (e_if || e_ls) m_last_ls = e_ls;
    end
    #1;
    check("if_rvalid", if_rvalid, m_if_rv);
    check("ls_rvalid", ls_rvalid, m_ls_rv);
    check("if_rdata", if_rdata, m_if_rdata);
    check("ls_rdata", ls_rdata, m_ls_rdata);
  endtask

  task automatic idle(input logic r);
    cycle(r, 1'b0, '0, 1'b0, 1'b0, '0, 4'h0, '0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    idle(1'b0);
    pre_en = 1'b0;
  endtask

  // Random traffic state: each port holds its request until granted.
  logic          rq_if = 1'b0, rq_ls = 1'b0, rq_we = 1'b0;
  logic [AW+1:0] rq_iaddr = '0, rq_laddr = '0;
  logic [3:0]    rq_be = '0;
  logic [31:0]   rq_wd = '0;

  initial begin
    idle(1'b1);
    idle(1'b1);
    check("rst_rd_addr", ram_rd_addr, '0);
    check("rst_wr_addr", ram_wr_addr, '0);
    check("rst_wr_data", ram_wr_data, '0);
    idle(1'b0);

    // Single fetch read.
    preload(8'h10, 32'hDEADBEEF);
    cycle(1'b0, 1'b1, 10'h040, 1'b0, 1'b0, '0, 4'h0, '0);
    check("tp_fetch_gnt", g_if, 1'b1);
    check("tp_fetch_rvalid", if_rvalid, 1'b1);
    check("tp_fetch_data", if_rdata, 32'hDEADBEEF);

    // Full store then load.
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 10'h080, 4'hF, 32'h12345678);
    check("tp_store_norv", ls_rvalid, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 10'h080, 4'h0, '0);
    check("tp_load_data", ls_rdata, 32'h12345678);

    // Partial store: merged write, no grant in the RMW cycle, read-back of the merged word.
    preload(8'h20, 32'hAABBCCDD);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 10'h081, 4'b0010, 32'h00001100);
    check("tp_rmw_gnt", g_ls, 1'b1);
    cycle(1'b0, 1'b1, 10'h080, 1'b1, 1'b0, 10'h080, 4'h0, '0);
    check("tp_rmw_nogrant", g_ls | g_if, 1'b0);
    check("tp_rmw_wr", g_wr, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 10'h080, 4'h0, '0);
    check("tp_rmw_next_gnt", g_ls, 1'b1);
    check("tp_rmw_merged", ls_rdata, 32'hAABB11DD);

    // Contention right after reset.
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 10'h040, 1'b1, 1'b0, 10'h080, 4'h0, '0);
`ifdef RAM_ARB_RR_EN
      check("tp_rr_if", g_if, (i % 2 == 0) ? 1'b1 : 1'b0);
`else
      check("tp_fixed_ls", g_ls, 1'b1);
`endif
    end

    // Reset during the RMW cycle aborts the write.
    preload(8'h05, 32'h11223344);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 10'h014, 4'b0001, 32'h000000FF);
    idle(1'b1);
    check("tp_abort_wr", g_wr, 1'b0);
    check("tp_abort_mem", mem[5], 32'h11223344);
    check("tp_abort_out", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, ram_rd_en, ram_wr_en}, '0);
    check("tp_abort_rdata", if_rdata | ls_rdata | ram_wr_data, '0);
    check("tp_abort_addr", {ram_rd_addr, ram_wr_addr}, '0);
    idle(1'b0);

    // Byte-enable-zero store.
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 10'h018, 4'h0, 32'hFFFFFFFF);
    check("tp_be0_gnt", g_ls, 1'b1);
    check("tp_be0_noacc", {g_rd, g_wr}, 2'b00);
    cycle(1'b0, 1'b1, 10'h018, 1'b0, 1'b0, '0, 4'h0, '0);
    check("tp_be0_idle", g_if, 1'b1);

    // Random traffic over a small address window so reads hit recent writes.
    for (int c = 0; c < 3000; c++) begin
      logic r;
      r = ($urandom_range(199) == 0);
      if (!rq_if && $urandom_range(2) != 0) begin
        rq_if = 1'b1;
        rq_iaddr = 10'($urandom_range(63));
      end
      if (!rq_ls && $urandom_range(2) != 0) begin
        rq_ls = 1'b1;
        rq_we = $urandom_range(1) != 0;
        rq_laddr = 10'($urandom_range(63));
        case ($urandom_range(3))
          0:       rq_be = 4'hF;
          1:       rq_be = 4'h0;
          default: rq_be = 4'($urandom_range(15));
        endcase
        rq_wd = $urandom;
      end
      cycle(r, rq_if, rq_iaddr, rq_ls, rq_we, rq_laddr, rq_be, rq_wd);
      if (g_if) rq_if = 1'b0;
      if (g_ls) rq_ls = 1'b0;
    end
    idle(1'b0);
    idle(1'b0);
    for (int w = 0; w < 32; w++) check("final_mem", mem[w], ref_mem[w]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
